fetch_unit: RTL

- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel, with one request outstanding at a time.
- Captures the returned word in a one-entry output register and presents {instruction, pc} to the decoder over a valid/ready handshake.
- Accepts redirects (taken branch, jal/jalr) from execute; all in-flight work on the old path is discarded.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_out_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, the canonical nop encoding and
// the fetch controller state type.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready pipeline register with load, consume and flush.
// Flush beats load, and load beats consume, so a same-cycle refill keeps valid high.
module fetch_out_reg #(
    parameter int           W          = 64,
    parameter logic [W-1:0] RESET_DATA = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         consume,
    input  logic         flush,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, one-entry output
// register toward decode, and redirect handling that squashes in-flight work.
module fetch_unit
    import cpu_pkg::fetch_state_t, cpu_pkg::REQ, cpu_pkg::WAIT, cpu_pkg::DRAIN,
           cpu_pkg::NOP_INSN, cpu_pkg::INSN_W;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INSN_W-1:0] out_instruction,
    output logic [XLEN-1:0]   out_pc
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_target;
    logic            slot_free;
    logic            req_allowed;
    logic            fill;
    logic            unused_redirect_lsbs;

    logic [INSN_W+XLEN-1:0] out_data;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign slot_free            = !out_valid || out_ready;
    // Gating with rst_n keeps the request line quiet for the whole reset pulse.
    assign req_allowed          = rst_n && slot_free && !redirect_valid;
    assign imem_req_addr        = pc_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imem_req_valid = 1'b0;
        fill           = 1'b0;
        case (state_q)
            REQ: begin
                imem_req_valid = req_allowed;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (req_allowed && imem_req_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = imem_rsp_valid ? REQ : DRAIN;
                end else if (imem_rsp_valid) begin
                    fill    = 1'b1;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // pc has already advanced past the word being returned, hence pc-4.
    fetch_out_reg #(
        .W          (INSN_W + XLEN),
        .RESET_DATA ({NOP_INSN, {XLEN{1'b0}}})
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (fill),
        .load_data ({imem_rsp_data, pc_q - XLEN'(4)}),
        .consume   (out_ready),
        .flush     (redirect_valid),
        .valid     (out_valid),
        .data      (out_data)
    );

    assign {out_instruction, out_pc} = out_data;

endmodule
